// File: rtl/byte_mem_ctrl.sv
// Byte-addressed word memory with byte write strobes, a valid/ready request/response port and RD_LATENCY response delay.
// Define MEM_ADDR_CHECK_EN to flag misaligned or out-of-range accesses on rsp_err.
module byte_mem_ctrl #(
  parameter int MEM_DEPTH  = 1024,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int SHIFT = $clog2(NB);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [1:0]            state;
  logic [1:0]            lat_cnt;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [IDX_W-1:0]      mem_idx;
  logic                  in_range;
  logic                  addr_err;
  logic                  mem_ok;
  logic                  accept;
  logic                  wr_en;

  assign word_idx = req_addr >> SHIFT;
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign in_range = word_idx < ADDR_WIDTH'(MEM_DEPTH);

`ifdef MEM_ADDR_CHECK_EN
  logic err_q;
  assign addr_err = !in_range || ((req_addr & ADDR_WIDTH'(NB - 1)) != '0);
  assign rsp_err  = err_q;
`else
  assign addr_err = 1'b0;
  assign rsp_err  = 1'b0;
`endif

  // Out-of-range accesses never touch the array, with or without checking.
  assign mem_ok    = in_range && !addr_err;
  assign req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
  assign accept    = req_valid && req_ready;
  assign wr_en     = accept && req_we && mem_ok;

  // Array has no reset; a write accepted just before reset stays committed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (req_be[b]) mem[mem_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat_cnt   <= 2'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef MEM_ADDR_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else if (accept) begin
      // Read data is captured at acceptance and held until the response handshake.
      rsp_rdata <= (!req_we && mem_ok) ? mem[mem_idx] : '0;
`ifdef MEM_ADDR_CHECK_EN
      err_q     <= addr_err;
`endif
      if (RD_LATENCY == 1) begin
        state     <= RESP;
        rsp_valid <= 1'b1;
      end else begin
        state     <= WAIT;
        rsp_valid <= 1'b0;
        lat_cnt   <= 2'(RD_LATENCY - 2);
      end
    end else begin
      case (state)
        WAIT: begin
          if (lat_cnt == 2'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        IDLE: state <= IDLE;
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// Directed bench for byte_mem_ctrl: three instances at RD_LATENCY 1, 3 and 4 sharing one clock and reset.
module tb_byte_mem_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 1024;
  localparam int N     = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          req_valid [N];
  logic          req_ready [N];
  logic          req_we    [N];
  logic [3:0]    req_be    [N];
  logic [AW-1:0] req_addr  [N];
  logic [DW-1:0] req_wdata [N];
  logic          rsp_valid [N];
  logic          rsp_ready [N];
  logic [DW-1:0] rsp_rdata [N];
  logic          rsp_err   [N];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    byte_mem_ctrl #(
      .MEM_DEPTH (DEPTH),
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .RD_LATENCY((g == 0) ? 1 : g + 2)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_we   (req_we[g]),
      .req_be   (req_be[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g])
    );
  end

  // Time from accept edge to the first falling edge with rsp_valid high.
  function automatic time exp_lat(input int d);
    return (d == 0) ? 5 : (d + 1) * 10 + 5;
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input int d, input logic we, input logic [3:0] be,
                      input logic [AW-1:0] addr, input logic [DW-1:0] wd, output time acc);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_be[d]    = be;
    req_addr[d]  = addr;
    req_wdata[d] = wd;
    acc = 0;
    for (int i = 0; i < 20 && acc == 0; i++) begin
      #1;
      if (req_ready[d]) begin
        @(posedge clk);
        acc = $time;
      end
      @(negedge clk);
    end
    req_valid[d] = 1'b0;
    checks++;
    if (acc == 0) begin
      errors++;
      $display("FAIL accept_timeout dut%0d addr %h: not accepted, required within 20 cycles", d, addr);
    end
  endtask

  task automatic wait_rsp(input int d, output time t, output logic [DW-1:0] data, output logic err);
    t = 0;
    data = '0;
    err = 1'b0;
    for (int i = 0; i < 20 && t == 0; i++) begin
      if (rsp_valid[d]) begin
        t = $time;
        data = rsp_rdata[d];
        err = rsp_err[d];
      end else begin
        @(negedge clk);
      end
    end
    checks++;
    if (t == 0) begin
      errors++;
      $display("FAIL rsp_timeout dut%0d: no rsp_valid, required within 20 cycles", d);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < N; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_be[d] = 4'h0;
      req_addr[d] = '0; req_wdata[d] = '0; rsp_ready[d] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < N; d++) begin
      checks += 4;
      if (rsp_valid[d] !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid dut%0d got %b want 0", d, rsp_valid[d]); end
      if (rsp_rdata[d] !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata dut%0d got %h want 0", d, rsp_rdata[d]); end
      if (rsp_err[d] !== 1'b0) begin errors++; $display("FAIL reset_rsp_err dut%0d got %b want 0", d, rsp_err[d]); end
      if (req_ready[d] !== 1'b1) begin errors++; $display("FAIL reset_req_ready dut%0d got %b want 1", d, req_ready[d]); end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    time acc, t;
    logic [DW-1:0] data;
    logic err;
    send(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, acc);
    wait_rsp(0, t, data, err);
    checks += 3;
    if (t - acc !== exp_lat(0)) begin errors++; $display("FAIL basic_wr_latency got %0t want %0t", t - acc, exp_lat(0)); end
    if (data !== 32'h0) begin errors++; $display("FAIL basic_wr_rdata got %h want 0", data); end
    if (err !== 1'b0) begin errors++; $display("FAIL basic_wr_err got %b want 0", err); end
    send(0, 1'b0, 4'h0, 32'h10, 32'h0, acc);
    wait_rsp(0, t, data, err);
    checks += 3;
    if (t - acc !== exp_lat(0)) begin errors++; $display("FAIL basic_rd_latency got %0t want %0t", t - acc, exp_lat(0)); end
    if (data !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rd_rdata got %h want deadbeef", data); end
    if (err !== 1'b0) begin errors++; $display("FAIL basic_rd_err got %b want 0", err); end
  endtask

  task automatic test_byte_strobe();
    time acc, t;
    logic [DW-1:0] data;
    logic err;
    send(0, 1'b1, 4'b0010, 32'h10, 32'h0000AA00, acc);
    wait_rsp(0, t, data, err);
    send(0, 1'b0, 4'hF, 32'h10, 32'hFFFFFFFF, acc);
    wait_rsp(0, t, data, err);
    checks++;
    if (data !== 32'hDEADAAEF) begin errors++; $display("FAIL byte_strobe_rdata got %h want deadaaef", data); end
  endtask

  task automatic test_backpressure();
    time acc, t, t0;
    logic [DW-1:0] data;
    logic err;
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    send(0, 1'b0, 4'h0, 32'h10, 32'h0, acc);
    for (int k = 0; k < 5; k++) begin
      #1;
      checks += 3;
      if (rsp_valid[0] !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid cycle %0d got %b want 1", k, rsp_valid[0]); end
      if (rsp_rdata[0] !== 32'hDEADAAEF) begin errors++; $display("FAIL bp_rsp_rdata cycle %0d got %h want deadaaef", k, rsp_rdata[0]); end
      if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_req_ready cycle %0d got %b want 0", k, req_ready[0]); end
      @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    t0 = $time;
    send(0, 1'b1, 4'hF, 32'h14, 32'h55667788, acc);
    checks++;
    if (acc !== t0 + 5) begin errors++; $display("FAIL bp_same_cycle_accept got %0t want %0t", acc, t0 + 5); end
    wait_rsp(0, t, data, err);
    checks++;
    if (data !== 32'h0) begin errors++; $display("FAIL bp_wr_rdata got %h want 0", data); end
  endtask

  task automatic test_latency();
    time acc, t;
    logic [DW-1:0] data;
    logic err;
    send(1, 1'b1, 4'hF, 32'h40, 32'hCAFEF00D, acc);
    for (int k = 0; k < 2; k++) begin
      #1;
      checks += 2;
      if (rsp_valid[1] !== 1'b0) begin errors++; $display("FAIL wait_rsp_valid cycle %0d got %b want 0", k, rsp_valid[1]); end
      if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL wait_req_ready cycle %0d got %b want 0", k, req_ready[1]); end
      @(negedge clk);
    end
    wait_rsp(1, t, data, err);
    checks++;
    if (t - acc !== exp_lat(1)) begin errors++; $display("FAIL lat3_wr got %0t want %0t", t - acc, exp_lat(1)); end
    for (int r = 0; r < 2; r++) begin
      send(1, 1'b0, 4'h0, 32'h40, 32'h0, acc);
      checks++;
      if (acc !== t + 5) begin errors++; $display("FAIL lat3_no_bubble rd%0d got %0t want %0t", r, acc, t + 5); end
      wait_rsp(1, t, data, err);
      checks += 2;
      if (t - acc !== exp_lat(1)) begin errors++; $display("FAIL lat3_rd%0d_latency got %0t want %0t", r, t - acc, exp_lat(1)); end
      if (data !== 32'hCAFEF00D) begin errors++; $display("FAIL lat3_rd%0d_rdata got %h want cafef00d", r, data); end
    end
  endtask

  task automatic test_addr();
    time acc, t;
    logic [DW-1:0] data;
    logic err;
    logic exp_err;
`ifdef MEM_ADDR_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    send(0, 1'b1, 4'hF, (DEPTH - 1) * 4, 32'h0BADC0DE, acc);
    wait_rsp(0, t, data, err);
    send(0, 1'b1, 4'hF, DEPTH * 4, 32'hFFFFFFFF, acc);
    wait_rsp(0, t, data, err);
    checks += 2;
    if (err !== exp_err) begin errors++; $display("FAIL oor_wr_err got %b want %b", err, exp_err); end
    if (data !== 32'h0) begin errors++; $display("FAIL oor_wr_rdata got %h want 0", data); end
    send(0, 1'b0, 4'h0, (DEPTH - 1) * 4, 32'h0, acc);
    wait_rsp(0, t, data, err);
    checks += 2;
    if (data !== 32'h0BADC0DE) begin errors++; $display("FAIL last_word_unchanged got %h want 0badc0de", data); end
    if (err !== 1'b0) begin errors++; $display("FAIL last_word_err got %b want 0", err); end
    send(0, 1'b0, 4'h0, DEPTH * 4, 32'h0, acc);
    wait_rsp(0, t, data, err);
    checks += 2;
    if (data !== 32'h0) begin errors++; $display("FAIL oor_rd_rdata got %h want 0", data); end
    if (err !== exp_err) begin errors++; $display("FAIL oor_rd_err got %b want %b", err, exp_err); end
    send(0, 1'b0, 4'h0, 32'h12, 32'h0, acc);
    wait_rsp(0, t, data, err);
    checks += 2;
`ifdef MEM_ADDR_CHECK_EN
    if (data !== 32'h0) begin errors++; $display("FAIL misaligned_rdata got %h want 0", data); end
`else
    if (data !== 32'hDEADAAEF) begin errors++; $display("FAIL misaligned_rdata got %h want deadaaef", data); end
`endif
    if (err !== exp_err) begin errors++; $display("FAIL misaligned_err got %b want %b", err, exp_err); end
  endtask

  task automatic test_reset_mid();
    time acc, t;
    logic [DW-1:0] data;
    logic err;
    int seen;
    send(2, 1'b1, 4'hF, 32'h20, 32'h12345678, acc);
    #1 rst_n = 1'b0;
    #1;
    checks += 2;
    if (rsp_valid[2] !== 1'b0) begin errors++; $display("FAIL rstmid_rsp_valid got %b want 0", rsp_valid[2]); end
    if (req_ready[2] !== 1'b1) begin errors++; $display("FAIL rstmid_req_ready got %b want 1", req_ready[2]); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid[2] !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rstmid_stale_rsp got %0d valid cycles want 0", seen); end
    send(2, 1'b0, 4'h0, 32'h20, 32'h0, acc);
    wait_rsp(2, t, data, err);
    checks += 2;
    if (data !== 32'h12345678) begin errors++; $display("FAIL rstmid_committed got %h want 12345678", data); end
    if (t - acc !== exp_lat(2)) begin errors++; $display("FAIL rstmid_lat4 got %0t want %0t", t - acc, exp_lat(2)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_strobe();
    test_backpressure();
    test_latency();
    test_addr();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
